// File: rtl/mult_leak_pkg.sv
// mult_leak_pkg
//   Shared types and helpers for the multiplier timing-leak checker.
//   - state_t     : checker FSM states (IDLE, RUN, DONE)
//   - lane_idx_w  : width of a lane index, never narrower than one bit
//   - sat_inc     : increment that sticks at the all-ones value of a w-bit counter
package mult_leak_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int lane_idx_w(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

  // w must be below 32; the caller truncates the result back to w bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (32'd1 << w) - 32'd1;
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/mult_ct_lane.sv
// mult_ct_lane
//   One constant-time unsigned shift-add multiplier. Always performs exactly
//   WIDTH iterations regardless of operand values; an iteration is skipped
//   (held) in any cycle where stall is high.
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   load                      latch operands, clear product, restart iteration count
//   run                       iterations may advance only while high
//   stall                     hold the current iteration this cycle
//   multiplier, multiplicand  WIDTH-bit unsigned operands
//   done                      one-cycle pulse after the final iteration
//   product                   2*WIDTH-bit result, held until the next load
module mult_ct_lane
  import mult_leak_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic               stall,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int IW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [IW-1:0]      iter_reg;
  logic               active_reg;
  logic               done_reg;
  logic               step;
  logic [2*WIDTH-1:0] addend;

  assign step = run && active_reg && !stall;
  // The add is formed every iteration so a zero bit costs the same as a one bit.
  assign addend = mplier_reg[0] ? mcand_reg : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      iter_reg   <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        mcand_reg  <= {{WIDTH{1'b0}}, multiplicand};
        mplier_reg <= multiplier;
        acc_reg    <= '0;
        iter_reg   <= '0;
        active_reg <= 1'b1;
      end else if (step) begin
        acc_reg    <= acc_reg + addend;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        iter_reg   <= iter_reg + 1'b1;
        if (iter_reg == IW'(WIDTH - 1)) begin
          active_reg <= 1'b0;
          done_reg   <= 1'b1;
        end
      end
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/multiplier_timing_leak_checker.sv
// multiplier_timing_leak_checker
//   Runs LANES constant-time multipliers in lock-step from one start, measures
//   each lane's start-to-done latency and flags a timing leak when any lane's
//   latency differs from lane 0, reporting the lowest diverging lane.
//   Optional watchdog: define MULT_LEAK_TIMEOUT_EN to abort a run after TIMEOUT
//   RUN cycles (timeout=1, leak_lane = lowest unfinished lane). Without it the
//   timeout output is tied low and RUN waits indefinitely.
// Ports
//   clk, rst       clock, asynchronous active-low reset
//   start          launch all lanes (accepted in IDLE or DONE)
//   multiplier     lane i operand at [i*WIDTH +: WIDTH]
//   multiplicand   lane i operand at [i*WIDTH +: WIDTH]
//   stall          per-lane iteration hold
//   busy           high in RUN
//   done           high in DONE; results valid
//   product        lane i result at [i*2*WIDTH +: 2*WIDTH]
//   lane_done      sticky per-lane completion for the current run
//   latency0       lane 0 latency in cycles
//   timing_leak    any lane latency differs from lane 0 (or watchdog fired)
//   leak_lane      lowest offending lane index, 0 if none
//   timeout        run aborted by the watchdog
module multiplier_timing_leak_checker
  import mult_leak_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LANES   = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4 * WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LANES*WIDTH-1:0]      multiplier,
  input  logic [LANES*WIDTH-1:0]      multiplicand,
  input  logic [LANES-1:0]            stall,
  output logic                        busy,
  output logic                        done,
  output logic [LANES*2*WIDTH-1:0]    product,
  output logic [LANES-1:0]            lane_done,
  output logic [CNT_W-1:0]            latency0,
  output logic                        timing_leak,
  output logic [lane_idx_w(LANES)-1:0] leak_lane,
  output logic                        timeout
);

  localparam int LIW = lane_idx_w(LANES);

  state_t             state_reg, state_next;
  logic               launch;
  logic               running;
  logic               finish;
  logic               tmo_hit;
  logic [LANES-1:0]   lane_fin;
  logic [LANES-1:0]   lane_done_reg;
  logic [LANES-1:0]   lane_end;
  logic [CNT_W-1:0]   lat_reg [LANES];
  logic               leak_any;
  logic [LIW-1:0]     leak_idx;
  logic [LIW-1:0]     unfin_idx;
  logic               timing_leak_reg;
  logic [LIW-1:0]     leak_lane_reg;
  logic               timeout_reg;

  assign running = (state_reg == RUN);
  assign launch  = start && (state_reg != RUN);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      mult_ct_lane #(.WIDTH(WIDTH)) u_lane (
        .clk          (clk),
        .rst          (rst),
        .load         (launch),
        .run          (running),
        .stall        (stall[gi]),
        .multiplier   (multiplier[gi*WIDTH +: WIDTH]),
        .multiplicand (multiplicand[gi*WIDTH +: WIDTH]),
        .done         (lane_fin[gi]),
        .product      (product[gi*2*WIDTH +: 2*WIDTH])
      );
      // A lane stops counting in the cycle its done pulse is visible, so an
      // unstalled lane freezes at exactly WIDTH.
      assign lane_end[gi] = lane_done_reg[gi] | lane_fin[gi];
    end
  endgenerate

`ifdef MULT_LEAK_TIMEOUT_EN
  logic [CNT_W-1:0] run_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_reg <= '0;
    end else if (launch) begin
      run_cnt_reg <= '0;
    end else if (running) begin
      run_cnt_reg <= CNT_W'(sat_inc(32'(run_cnt_reg), CNT_W));
    end
  end

  // Fires on the TIMEOUT-th RUN cycle so DONE is entered exactly then.
  assign tmo_hit = (32'(run_cnt_reg) >= 32'(TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT;   // TIMEOUT only matters with the watchdog build
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    finish     = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (&lane_done_reg || tmo_hit) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      DONE: if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Descending scans so the lowest qualifying lane is the one left standing.
  always_comb begin
    leak_any  = 1'b0;
    leak_idx  = '0;
    unfin_idx = '0;
    for (int i = LANES - 1; i >= 1; i--) begin
      if (lat_reg[i] != lat_reg[0]) begin
        leak_any = 1'b1;
        leak_idx = LIW'(i);
      end
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (!lane_end[i]) unfin_idx = LIW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_done_reg <= '0;
      for (int i = 0; i < LANES; i++) lat_reg[i] <= '0;
    end else if (launch) begin
      lane_done_reg <= '0;
      for (int i = 0; i < LANES; i++) lat_reg[i] <= '0;
    end else if (running) begin
      lane_done_reg <= lane_done_reg | lane_fin;
      for (int i = 0; i < LANES; i++) begin
        if (!lane_end[i]) lat_reg[i] <= CNT_W'(sat_inc(32'(lat_reg[i]), CNT_W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timing_leak_reg <= 1'b0;
      leak_lane_reg   <= '0;
      timeout_reg     <= 1'b0;
    end else if (launch) begin
      timing_leak_reg <= 1'b0;
      leak_lane_reg   <= '0;
      timeout_reg     <= 1'b0;
    end else if (finish) begin
      // Normal completion takes priority over a watchdog hit in the same cycle.
      if (!(&lane_done_reg) && tmo_hit) begin
        timing_leak_reg <= 1'b1;
        leak_lane_reg   <= unfin_idx;
        timeout_reg     <= 1'b1;
      end else begin
        timing_leak_reg <= leak_any;
        leak_lane_reg   <= leak_idx;
      end
    end
  end

  assign busy        = running;
  assign done        = (state_reg == DONE);
  assign lane_done   = lane_done_reg;
  assign latency0    = lat_reg[0];
  assign timing_leak = timing_leak_reg;
  assign leak_lane   = leak_lane_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_multiplier_timing_leak_checker.sv
// Directed bench for multiplier_timing_leak_checker (WIDTH=4, LANES=4, TIMEOUT=16).
// Covers MULT_LEAK_TIMEOUT_EN in both builds.
module tb_multiplier_timing_leak_checker;

  localparam int WIDTH   = 4;
  localparam int LANES   = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic [LANES*WIDTH-1:0]   multiplier;
  logic [LANES*WIDTH-1:0]   multiplicand;
  logic [LANES-1:0]         stall;
  logic                     busy;
  logic                     done;
  logic [LANES*2*WIDTH-1:0] product;
  logic [LANES-1:0]         lane_done;
  logic [CNT_W-1:0]         latency0;
  logic                     timing_leak;
  logic [1:0]               leak_lane;
  logic                     timeout;

  int n_checks = 0;
  int n_fail   = 0;

  multiplier_timing_leak_checker #(
    .WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .lane_done    (lane_done),
    .latency0     (latency0),
    .timing_leak  (timing_leak),
    .leak_lane    (leak_lane),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prod(input int i);
    return 32'(product[i*8 +: 8]);
  endfunction

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    chk({tag, "_done_reached"}, 32'(done), 1);
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    stall        = '0;
    multiplier   = '0;
    multiplicand = '0;
    #12;
    // Reset state
    chk("rst_busy",      32'(busy), 0);
    chk("rst_done",      32'(done), 0);
    chk("rst_product",   32'(product), 0);
    chk("rst_lane_done", 32'(lane_done), 0);
    chk("rst_latency0",  32'(latency0), 0);
    chk("rst_leak",      32'(timing_leak), 0);
    chk("rst_timeout",   32'(timeout), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // 1: 13*11, 7*0, 15*15, 0*9, no stall
    multiplier   = {4'd0, 4'd15, 4'd7, 4'd13};
    multiplicand = {4'd9, 4'd15, 4'd0, 4'd11};
    launch();
    chk("t1_busy", 32'(busy), 1);
    tick(5);
    chk("t1_done_early", 32'(done), 0);
    tick();
    chk("t1_done_edge6", 32'(done), 1);
    chk("t1_p0", prod(0), 143);
    chk("t1_p1", prod(1), 0);
    chk("t1_p2", prod(2), 225);
    chk("t1_p3", prod(3), 0);
    chk("t1_latency0", 32'(latency0), 4);
    chk("t1_leak", 32'(timing_leak), 0);
    chk("t1_leak_lane", 32'(leak_lane), 0);
    chk("t1_lane_done", 32'(lane_done), 15);
    chk("t1_busy_off", 32'(busy), 0);

    // 2: lane 2 stalled 3 cycles mid-run
    multiplier   = {4'd15, 4'd9, 4'd2, 4'd5};
    multiplicand = {4'd1, 4'd6, 4'd8, 4'd3};
    launch();
    tick();
    stall = 4'b0100;
    tick(3);
    stall = '0;
    wait_done("t2", 20);
    chk("t2_leak", 32'(timing_leak), 1);
    chk("t2_leak_lane", 32'(leak_lane), 2);
    chk("t2_latency0", 32'(latency0), 4);
    chk("t2_p0", prod(0), 15);
    chk("t2_p1", prod(1), 16);
    chk("t2_p2", prod(2), 54);
    chk("t2_p3", prod(3), 15);

    // 3: lanes 1 and 3 stalled one cycle, lowest lane reported
    launch();
    stall = 4'b1010;
    tick();
    stall = '0;
    wait_done("t3", 20);
    chk("t3_leak", 32'(timing_leak), 1);
    chk("t3_leak_lane", 32'(leak_lane), 1);
    chk("t3_latency0", 32'(latency0), 4);

    // 4: restart from DONE clears results; start during RUN ignored
    launch();
    chk("t4_leak_cleared", 32'(timing_leak), 0);
    chk("t4_leak_lane_cleared", 32'(leak_lane), 0);
    chk("t4_lane_done_cleared", 32'(lane_done), 0);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_done_low", 32'(done), 0);
    tick();
    start      = 1'b1;
    multiplier = {4'd15, 4'd9, 4'd2, 4'd1};
    tick();
    start = 1'b0;
    chk("t4_still_busy", 32'(busy), 1);
    tick(3);
    chk("t4_done_early", 32'(done), 0);
    tick();
    chk("t4_done_edge6", 32'(done), 1);
    chk("t4_p0_not_relatched", prod(0), 15);
    chk("t4_leak", 32'(timing_leak), 0);

    // 5: reset in RUN cycle 2
    multiplier   = {4'd0, 4'd15, 4'd7, 4'd13};
    multiplicand = {4'd9, 4'd15, 4'd0, 4'd11};
    launch();
    tick(2);
    rst = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_product", 32'(product), 0);
    chk("t5_lane_done", 32'(lane_done), 0);
    chk("t5_latency0", 32'(latency0), 0);
    #2 rst = 1'b1;
    tick();
    chk("t5_idle", 32'(busy), 0);

    // 6: lane 1 stalled forever
    stall = 4'b0010;
    launch();
`ifdef MULT_LEAK_TIMEOUT_EN
    tick(15);
    chk("t6_done_early", 32'(done), 0);
    tick();
    chk("t6_done_edge16", 32'(done), 1);
    chk("t6_timeout", 32'(timeout), 1);
    chk("t6_leak", 32'(timing_leak), 1);
    chk("t6_leak_lane", 32'(leak_lane), 1);
`else
    tick(20);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_timeout", 32'(timeout), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_lane_done", 32'(lane_done), 13);
`endif
    stall = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
